// File: rtl/multi_channel_sync_debounce_if.sv
// -----------------------------------------------------------------------------
// multi_channel_sync_debounce_if
//
// Purpose:
//   Groups the level-signal bundle of the multi-channel synchroniser /
//   debouncer into one interface. Clock and reset stay plain module ports.
//
// Signals:
//   async_in    [WIDTH] asynchronous level inputs (driven by the master)
//   sync_out    [WIDTH] last synchroniser stage, raw and undebounced
//   stable_out  [WIDTH] debounced level per channel
//   rise_pulse  [WIDTH] one-cycle pulse on a stable 0->1 change
//   fall_pulse  [WIDTH] one-cycle pulse on a stable 1->0 change
//   change_any  [1]     one-cycle pulse when any stable bit changes
//
// Modports:
//   master : the environment; drives async_in and observes the results
//   slave  : the synchroniser/debouncer; consumes async_in, drives the rest
// -----------------------------------------------------------------------------
interface multi_channel_sync_debounce_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             change_any;

    modport master (
        output async_in,
        input  sync_out,
        input  stable_out,
        input  rise_pulse,
        input  fall_pulse,
        input  change_any
    );

    modport slave (
        input  async_in,
        output sync_out,
        output stable_out,
        output rise_pulse,
        output fall_pulse,
        output change_any
    );

endinterface

// File: rtl/multi_channel_sync_debounce.sv
// -----------------------------------------------------------------------------
// multi_channel_sync_debounce
//
// Purpose:
//   Brings WIDTH independent asynchronous level signals (buttons, status
//   lines, slow control bits) into the clk domain. Each channel passes through
//   a STAGES-deep flop chain and is then debounced by its own stability
//   counter: the synchronised value must differ from the current stable value
//   on DEBOUNCE_CYCLES consecutive edges before the stable value follows it.
//   Every debounced change produces a registered rise or fall pulse, and a
//   registered change_any pulse summarises all channels.
//
// Parameters:
//   WIDTH           number of channels (>= 1)
//   STAGES          synchroniser depth per channel (>= 2)
//   DEBOUNCE_CYCLES consecutive differing edges needed to accept a change (>= 1)
//   RESET_VAL       value loaded into every sync stage and stable_out on reset
//
// Ports:
//   clk  rising-edge clock for every flop
//   rst  synchronous, active-high reset
//   bus  slave side of multi_channel_sync_debounce_if
//        (async_in in; sync_out, stable_out, rise_pulse, fall_pulse,
//         change_any out -- all outputs come straight from flops)
// -----------------------------------------------------------------------------
module multi_channel_sync_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst,
    multi_channel_sync_debounce_if.slave   bus
);

    // A single-cycle debounce still needs a one-bit counter so the compare
    // against CNT_MAX (which is then zero) stays uniform.
    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [STAGES];   // r_sync[0] samples async_in
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // -------------------------------------------------------------------------
    // Next-state terms
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_differ;
    logic [WIDTH-1:0] w_update;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic             w_change_nxt;

    assign w_sync = r_sync[STAGES-1];

    // Synchroniser chain: reset to RESET_VAL, otherwise shift async_in inward.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_sync[s] <= RESET_VAL;
            end
        end else begin
            r_sync[0] <= bus.async_in;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Per-channel debounce decision: clear on agreement, accept on the
    // DEBOUNCE_CYCLES-th consecutive disagreement, otherwise keep counting.
    // The counter is cleared when it reaches CNT_MAX, so it can never wrap.
    always_comb begin
        w_differ = {WIDTH{1'b0}};
        w_update = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = CNT_ZERO;
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_differ[i] = w_sync[i] ^ r_stable[i];
            if (!w_differ[i]) begin
                w_cnt_nxt[i] = CNT_ZERO;
                w_update[i]  = 1'b0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i] = CNT_ZERO;
                w_update[i]  = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                w_update[i]  = 1'b0;
            end
        end
    end

    // Stable value and edge pulses derived from the accepted updates. An
    // updating bit always takes the sync value, so the pulse direction is
    // simply the sync value itself; rise and fall are mutually exclusive.
    always_comb begin
        w_stable_nxt = r_stable ^ w_update;
        w_rise_nxt   = w_update & w_sync;
        w_fall_nxt   = w_update & ~w_sync;
        w_change_nxt = |w_update;
    end

    // Debounce counters: reset discards any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Stable levels and pulses: pulses load at the same edge as the new
    // stable value, so they coincide with its first visible cycle. Reset
    // forces the pulses low, so neither reset entry nor exit creates one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= RESET_VAL;
            r_rise   <= {WIDTH{1'b0}};
            r_fall   <= {WIDTH{1'b0}};
            r_change <= 1'b0;
        end else begin
            r_stable <= w_stable_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_change <= w_change_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all flop-driven)
    // -------------------------------------------------------------------------
    assign bus.sync_out   = w_sync;
    assign bus.stable_out = r_stable;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;
    assign bus.change_any = r_change;

endmodule
